// File: rtl/pc_seq_ctrl_if.sv
// Instruction-memory fetch bus between the sequencer (master) and memory (slave).
interface pc_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: fetch / execute FSM with jump, branch, halt and fetch-timeout handling.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 halt,
  pc_seq_ctrl_if.master        imem,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  input  logic                 exec_done,
  input  logic                 j_en,
  input  logic                 bgtz_en,
  input  logic                 br_taken,
  input  logic [16:0]          offset,
  output logic [31:0]          pc,
  output logic [2:0]           state,
  output logic                 err
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          vld_q, vld_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   pc_next;

  // Jump replaces the low 17 bits; branch is pc-relative with a signed field.
  always_comb begin
    if (j_en)
      pc_next = {pc_q[31:17], offset};
    else if (bgtz_en && br_taken)
      pc_next = pc_q + {{15{offset[16]}}, offset};
    else
      pc_next = pc_q + 32'd1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = 1'b0;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (run) begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          vld_d   = 1'b1;
          state_d = S_EXEC;
          wait_d  = '0;
        end else if (wait_q == WW'(MAX_WAIT - 1)) begin
          state_d = S_ERR;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      S_EXEC: if (exec_done) begin
        pc_d    = pc_next;
        state_d = halt ? S_HALT : S_FETCH;
        wait_d  = '0;
      end
      S_HALT: if (run) begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      vld_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      wait_q  <= wait_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = vld_q;
  assign pc             = pc_q;
  assign state          = state_q;
  assign err            = (state_q == S_ERR);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: reset, fetch/exec, jump/branch arithmetic, halt, timeout.
module tb_pc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, run, halt, exec_done, j_en, bgtz_en, br_taken;
  logic [16:0] offset;
  logic [31:0] instr, pc;
  logic        instr_valid, err;
  logic [2:0]  state;
  int          checks = 0;
  int          errors = 0;

  pc_seq_ctrl_if bus ();

  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .imem(bus),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .j_en(j_en), .bgtz_en(bgtz_en), .br_taken(br_taken), .offset(offset),
    .pc(pc), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // From FETCH: ack a word, then retire it with the given control; checks result pc/state.
  task automatic retire(input logic j, input logic b, input logic t, input logic [16:0] off,
                        input logic [31:0] exp_pc, input string tag);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = exp_pc ^ 32'hA5A5_0000;
    tick();
    bus.imem_ack = 1'b0;
    chk({tag, "_exec"}, {29'd0, state}, 32'd2);
    chk({tag, "_instr"}, instr, exp_pc ^ 32'hA5A5_0000);
    exec_done = 1'b1; j_en = j; bgtz_en = b; br_taken = t; offset = off;
    tick();
    exec_done = 1'b0; j_en = 1'b0; bgtz_en = 1'b0; br_taken = 1'b0; offset = '0;
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_fetch"}, {29'd0, state}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; halt = 1'b0; exec_done = 1'b0; j_en = 1'b0;
    bgtz_en = 1'b0; br_taken = 1'b0; offset = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Basic fetch / execute with first-cycle ack and done.
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("f_state", {29'd0, state}, 32'd1);
    chk("f_req", {31'd0, bus.imem_req}, 32'd1);
    chk("f_addr", bus.imem_addr, 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
    chk("e_state", {29'd0, state}, 32'd2);
    chk("e_instr", instr, 32'h1234_5678);
    chk("e_valid", {31'd0, instr_valid}, 32'd1);
    chk("e_req", {31'd0, bus.imem_req}, 32'd0);
    chk("e_pc", pc, 32'd0);
    tick();
    chk("e_hold_state", {29'd0, state}, 32'd2);
    chk("e_valid_pulse", {31'd0, instr_valid}, 32'd0);
    chk("e_hold_instr", instr, 32'h1234_5678);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("r_pc", pc, 32'd1);
    chk("r_state", {29'd0, state}, 32'd1);
    chk("r_addr", bus.imem_addr, 32'd1);

    // Jump / branch arithmetic chain.
    retire(1'b1, 1'b0, 1'b0, 17'h00010, 32'h0000_0010, "jmp10");
    retire(1'b0, 1'b1, 1'b1, 17'h1FFFC, 32'h0000_000C, "br_neg4");
    retire(1'b1, 1'b0, 1'b0, 17'h00010, 32'h0000_0010, "jmp10b");
    retire(1'b0, 1'b1, 1'b0, 17'h1FFFC, 32'h0000_0011, "br_untaken");
    retire(1'b1, 1'b0, 1'b0, 17'h0FFFF, 32'h0000_FFFF, "jmpFFFF");
    retire(1'b0, 1'b1, 1'b1, 17'h0FFFF, 32'h0001_FFFE, "br_pos1");
    retire(1'b0, 1'b1, 1'b1, 17'h0FFFF, 32'h0002_FFFD, "br_pos2");
    retire(1'b0, 1'b1, 1'b1, 17'h00008, 32'h0003_0005, "br_pos3");
    retire(1'b1, 1'b1, 1'b1, 17'h00100, 32'h0002_0100, "jmp_prio");
    retire(1'b0, 1'b1, 1'b1, 17'h10000, 32'h0001_0100, "br_min1");
    retire(1'b0, 1'b1, 1'b1, 17'h10000, 32'h0000_0100, "br_min2");
    retire(1'b0, 1'b1, 1'b1, 17'h1FEFF, 32'hFFFF_FFFF, "br_to_max");
    retire(1'b0, 1'b0, 1'b0, 17'h00000, 32'h0000_0000, "wrap");

    // Halt held through an instruction; halt in FETCH must not stop the fetch.
    halt = 1'b1;
    tick();
    chk("h_fetch_ignored", {29'd0, state}, 32'd1);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("h_state", {29'd0, state}, 32'd3);
    chk("h_pc", pc, 32'd1);
    chk("h_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("h_stay", {29'd0, state}, 32'd3);
    halt = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    chk("h_resume", {29'd0, state}, 32'd1);
    chk("h_resume_addr", bus.imem_addr, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rf_state", {29'd0, state}, 32'd0);
    chk("rf_pc", pc, 32'd0);

    // Fetch timeout: 14 idle FETCH cycles still fetching, the 15th lands in ERR.
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_still_fetch", {29'd0, state}, 32'd1);
    tick();
    chk("to_state", {29'd0, state}, 32'd4);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_req", {31'd0, bus.imem_req}, 32'd0);
    run = 1'b1; bus.imem_ack = 1'b1;
    tick(); tick();
    run = 1'b0; bus.imem_ack = 1'b0;
    chk("err_sticky", {29'd0, state}, 32'd4);
    chk("err_sticky_flag", {31'd0, err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_rst_state", {29'd0, state}, 32'd0);
    chk("err_rst_flag", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, the maximum number of FETCH cycles without imem_ack before error.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port run  in  1  start/resume request.
REQ-006 SHALL have port halt  in  1  stop after the current instruction.
REQ-007 SHALL have port imem_req  out  1  instruction fetch request.
REQ-008 SHALL have port imem_addr  out  32  word address of the fetch (equals pc).
REQ-009 SHALL have port imem_ack  in  1  fetch data valid this cycle.
REQ-010 SHALL have port imem_rdata  in  32  fetched instruction.
REQ-011 SHALL have port instr  out  32  latched instruction to decode.
REQ-012 SHALL have port instr_valid  out  1  one-cycle pulse: instr is newly latched.
REQ-013 SHALL have port exec_done  in  1  datapath retired the instruction.
REQ-014 SHALL have port j_en  in  1  retiring instruction is a jump.
REQ-015 SHALL have port bgtz_en  in  1  retiring instruction is a conditional branch.
REQ-016 SHALL have port br_taken  in  1  branch condition true.
REQ-017 SHALL have port offset  in  17  two's-complement jump/branch field.
REQ-018 SHALL have port pc  out  32  current word-addressed PC.
REQ-019 SHALL have port state  out  3  encoded FSM state: IDLE=0, FETCH=1, EXEC=2, HALT=3, ERR=4.
REQ-020 SHALL have port err  out  1  fetch timeout flag, sticky.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, EXEC, HALT and ERR.
REQ-022 IDLE: SHALL go to FETCH when run=1; otherwise SHALL stay in IDLE.
REQ-023 FETCH: SHALL drive imem_req=1 with imem_addr=pc held stable until imem_ack.
REQ-024 FETCH with imem_ack=1: SHALL latch imem_rdata into instr, pulse instr_valid for exactly the next cycle, go to EXEC, and drop imem_req the next cycle.
REQ-025 FETCH: SHALL keep a wait counter, cleared on entry; after MAX_WAIT consecutive cycles without ack, SHALL go to ERR.
REQ-026 ERR: SHALL hold err=1 and imem_req=0, and SHALL leave ERR only on rst.
REQ-027 EXEC: SHALL hold pc and instr until exec_done=1.
REQ-028 EXEC with exec_done=1: SHALL update pc per REQ-030..REQ-033.
REQ-029 After the update in REQ-028, SHALL go to HALT if halt=1 that cycle, else to FETCH.
REQ-030 Jump (j_en=1): SHALL set pc_next = {pc[31:17], offset[16:0]}.
REQ-031 Taken branch (bgtz_en=1, br_taken=1, j_en=0): SHALL set pc_next = pc + sign_extend32(offset), modulo 2^32.
REQ-032 All other cases, including an untaken branch: SHALL set pc_next = pc + 1, modulo 2^32, so 32'hFFFF_FFFF wraps to 0.
REQ-033 SHALL give j_en priority when j_en=1 and bgtz_en=1 together.
REQ-034 SHALL ignore halt asserted during FETCH and sample it only on the exec_done cycle.
REQ-035 HALT: SHALL go to FETCH on run=1 with pc unchanged.
REQ-036 SHALL ignore exec_done, j_en, bgtz_en and imem_ack outside the states where they are used.
REQ-037 Latency: SHALL take 2 cycles minimum per instruction (ack in the first FETCH cycle, exec_done in the first EXEC cycle).

Reset
REQ-038 On rst=1 at a clock edge, SHALL set state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, err=0, and wait counter=0.
REQ-039 SHALL give rst priority over all other inputs, including mid-FETCH and in ERR; imem_req SHALL be 0 the cycle after reset.

Verification
REQ-040 SHALL be verified by: rst, then run=1, ack on the first FETCH cycle with rdata=32'h1234_5678 -> instr=32'h1234_5678, instr_valid one pulse, pc=0 in EXEC; exec_done -> pc=1.
REQ-041 SHALL be verified by: pc=32'h0000_0010, bgtz_en=1, br_taken=1, offset=17'h1FFFC (-4), exec_done -> pc=32'h0000_000C; same with br_taken=0 -> pc=32'h0000_0011.
REQ-042 SHALL be verified by: pc=32'h0003_0005, j_en=1, bgtz_en=1, offset=17'h00100 -> pc=32'h0002_0100 (jump wins).
REQ-043 SHALL be verified by: pc=32'hFFFF_FFFF, plain retire -> pc=0.
REQ-044 SHALL be verified by: no imem_ack for 15 FETCH cycles -> state=ERR, err=1, imem_req=0; run ignored; rst -> IDLE, err=0.
REQ-045 SHALL be verified by: halt=1 throughout an instruction -> HALT after exec_done with the new pc; run=1 -> FETCH at that pc; rst during FETCH -> imem_req=0 the next cycle.
